// File: rtl/eth_decap.sv
// eth_decap: strips the 48-byte Ethernet/IPv4/UDP/tcap header from an AXI-Stream
// frame and writes the remaining TLP payload beats into a FIFO.
// Optional feature: define DECAP_SEQ_CHECK_EN to count tcap sequence gaps.
//
// Header byte map (wire byte offsets, 6 beats of 8 bytes):
//   0-5 dst MAC, 12-13 EtherType, 14 ver/ihl, 23 IP protocol,
//   36-37 UDP dest port, 42 tcap flags (dir in bits [1:0]), 44-47 tcap seq.
module eth_decap #(
  parameter logic [47:0] eth_dst   = 48'h00_11_22_33_44_55,
  parameter logic [15:0] udp_dport = 16'h3776,
  parameter logic [15:0] eth_proto = 16'h0800  // ETH_P_IP
)(
  input  logic        clk156,
  input  logic        sys_rst,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        wr_en,
  output logic [75:0] din,
  input  logic        full,
  output logic [31:0] pkt_cnt,
  output logic [31:0] drop_cnt,
  output logic [31:0] seq_err_cnt
);

  typedef enum logic [1:0] {RX_IDLE, RX_HDR, RX_DATA, RX_DROP} rx_state_t;
  localparam logic [7:0] IP4_PROTO_UDP = 8'd17;

  // First wire byte lands in the MSB so header fields read big-endian.
  function automatic logic [63:0] endian_conv64(input logic [63:0] x);
    logic [63:0] y;
    for (int k = 0; k < 8; k++) y[63-8*k -: 8] = x[8*k +: 8];
    return y;
  endfunction

  // Byte enables follow the byte swap: wire byte 0 enable moves to bit 7.
  function automatic logic [7:0] reverse8(input logic [7:0] x);
    logic [7:0] y;
    for (int k = 0; k < 8; k++) y[7-k] = x[k];
    return y;
  endfunction

  rx_state_t   r_state;
  logic [2:0]  r_hdr_cnt;
  logic        r_hdr_bad;
  logic [1:0]  r_dir;
  logic [31:0] r_seq;
  logic        r_live;
  logic [31:0] r_pkt_cnt;
  logic [31:0] r_drop_cnt;

  logic [63:0] w_data;
  logic [7:0]  w_keep;
  logic        w_beat;
  logic [2:0]  w_idx;
  logic        w_beat_bad;

  assign w_data = endian_conv64(s_axis_tdata);
  assign w_keep = reverse8(s_axis_tkeep);

  // r_live keeps tready low while reset is held; payload backpressure is zero-latency.
  assign s_axis_tready = r_live && ((r_state != RX_DATA) || !full);
  assign w_beat        = s_axis_tvalid && s_axis_tready;
  assign wr_en         = (r_state == RX_DATA) && w_beat;
  assign din           = (r_state == RX_DATA) ?
                         {r_dir, w_keep, w_data, s_axis_tlast, s_axis_tuser} : 76'h0;

  // Beat 0 arrives while still idle; later header beats are indexed by hdr_cnt.
  assign w_idx = (r_state == RX_IDLE) ? 3'd0 : r_hdr_cnt;

  // Per-beat header check against whichever fields this beat carries.
  always_comb begin
    w_beat_bad = 1'b0;
    case (w_idx)
      3'd0:    w_beat_bad = (w_data[63:16] != eth_dst);
      3'd1:    w_beat_bad = (w_data[31:16] != eth_proto) ||
                            (w_data[15:12] != 4'd4) || (w_data[11:8] != 4'd5);
      3'd2:    w_beat_bad = (w_data[7:0] != IP4_PROTO_UDP);
      3'd4:    w_beat_bad = (w_data[31:16] != udp_dport);
      default: w_beat_bad = 1'b0;
    endcase
  end

`ifdef DECAP_SEQ_CHECK_EN
  logic [31:0] r_exp_seq;
  logic [31:0] r_seq_err_cnt;
  assign seq_err_cnt = r_seq_err_cnt;

  // Sequence tracking: compare on each accepted frame, then resync to seq+1.
  always_ff @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) begin
      r_exp_seq     <= 32'd1;
      r_seq_err_cnt <= 32'd0;
    end else if (wr_en && s_axis_tlast) begin
      if (r_seq != r_exp_seq) r_seq_err_cnt <= r_seq_err_cnt + 32'd1;
      r_exp_seq <= r_seq + 32'd1;
    end
  end
`else
  logic w_unused_seq;
  assign w_unused_seq = ^r_seq;
  assign seq_err_cnt  = 32'h0;
`endif

  assign pkt_cnt  = r_pkt_cnt;
  assign drop_cnt = r_drop_cnt;

  // Receive FSM: header parse, then forward or discard the rest of the frame.
  always_ff @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= RX_IDLE;
      r_hdr_cnt  <= 3'd0;
      r_hdr_bad  <= 1'b0;
      r_dir      <= 2'd0;
      r_seq      <= 32'd0;
      r_live     <= 1'b0;
      r_pkt_cnt  <= 32'd0;
      r_drop_cnt <= 32'd0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        RX_IDLE: if (w_beat) begin
          r_hdr_bad <= w_beat_bad;
          if (s_axis_tlast) begin
            r_drop_cnt <= r_drop_cnt + 32'd1;
            r_hdr_cnt  <= 3'd0;
          end else begin
            r_state   <= RX_HDR;
            r_hdr_cnt <= 3'd1;
          end
        end
        RX_HDR: if (w_beat) begin
          r_hdr_bad <= r_hdr_bad | w_beat_bad;
          if (r_hdr_cnt == 3'd5) begin
            r_dir     <= w_data[41:40];
            r_seq     <= w_data[31:0];
            r_hdr_cnt <= 3'd0;
            if (s_axis_tlast) begin
              // header-only frame carries no payload: discard
              r_state    <= RX_IDLE;
              r_drop_cnt <= r_drop_cnt + 32'd1;
            end else if (r_hdr_bad || w_beat_bad) begin
              r_state <= RX_DROP;
            end else begin
              r_state <= RX_DATA;
            end
          end else if (s_axis_tlast) begin
            r_state    <= RX_IDLE;
            r_hdr_cnt  <= 3'd0;
            r_drop_cnt <= r_drop_cnt + 32'd1;
          end else begin
            r_hdr_cnt <= r_hdr_cnt + 3'd1;
          end
        end
        RX_DATA: if (w_beat && s_axis_tlast) begin
          r_state   <= RX_IDLE;
          r_pkt_cnt <= r_pkt_cnt + 32'd1;
        end
        RX_DROP: if (w_beat && s_axis_tlast) begin
          r_state    <= RX_IDLE;
          r_drop_cnt <= r_drop_cnt + 32'd1;
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_decap.sv
// tb_eth_decap: directed scenarios plus randomized frames for eth_decap,
// checked against a frame-level byte model.
module tb_eth_decap;

  localparam logic [47:0] DST   = 48'h00_11_22_33_44_55;
  localparam logic [15:0] DPORT = 16'h3776;

  logic        clk156 = 1'b0;
  logic        sys_rst = 1'b1;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [63:0] s_axis_tdata = '0;
  logic [7:0]  s_axis_tkeep = '0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic        wr_en;
  logic [75:0] din;
  logic        full = 1'b0;
  logic [31:0] pkt_cnt, drop_cnt, seq_err_cnt;

  eth_decap dut (
    .clk156(clk156), .sys_rst(sys_rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .wr_en(wr_en), .din(din), .full(full),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .seq_err_cnt(seq_err_cnt)
  );

  always #5 clk156 = ~clk156;

  int total = 0, bad = 0;
  int n_wr = 0;
  int gap_pct = 0;
  logic full_force = 1'b0, full_rand = 1'b0, rdy_watch = 1'b0;

  // model state
  logic [7:0]  fr[$];
  logic        tu[$];
  int          flen;
  logic [75:0] exp_q[$], got_q[$];
  int          m_pkt = 0, m_drop = 0, m_err = 0;
  logic [31:0] m_exp = 32'd1;

  task automatic chk(string nm, logic [75:0] act, logic [75:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic chki(string nm, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic int nbeats();
    return (flen + 7) / 8;
  endfunction

  function automatic logic [63:0] beat_data(int b);
    logic [63:0] d;
    for (int k = 0; k < 8; k++) d[8*k +: 8] = fr[8*b+k];
    return d;
  endfunction

  function automatic logic [7:0] beat_keep(int b);
    int rem;
    rem = flen - 8*b;
    if (rem >= 8) return 8'hFF;
    return 8'((1 << rem) - 1);
  endfunction

  // Internal order: first wire byte in the top byte, keep bit-reversed.
  function automatic logic [63:0] bswap(logic [63:0] x);
    logic [63:0] y;
    for (int k = 0; k < 8; k++) y[63-8*k -: 8] = x[8*k +: 8];
    return y;
  endfunction

  function automatic logic [7:0] rev8(logic [7:0] x);
    logic [7:0] y;
    for (int k = 0; k < 8; k++) y[7-k] = x[k];
    return y;
  endfunction

  task automatic put(int idx, logic [7:0] v);
    if (idx < fr.size()) fr[idx] = v;
  endtask

  // Build a frame of len bytes with a valid header, optionally corrupting one field.
  task automatic mk_frame(int len, logic [1:0] dir, logic [31:0] seq, int corrupt);
    fr.delete(); tu.delete();
    flen = len;
    for (int i = 0; i < ((len + 7) / 8) * 8; i++) fr.push_back(8'($urandom));
    for (int b = 0; b < (len + 7) / 8; b++) tu.push_back(1'($urandom_range(0, 1)));
    for (int i = 0; i < 6; i++) put(i, DST[47-8*i -: 8]);
    put(12, 8'h08); put(13, 8'h00); put(14, 8'h45); put(23, 8'h11);
    put(36, DPORT[15:8]); put(37, DPORT[7:0]);
    put(42, {6'($urandom), dir});
    for (int i = 0; i < 4; i++) put(44 + i, seq[31-8*i -: 8]);
    case (corrupt)
      1: put(2, 8'h23);
      2: put(13, 8'h06);
      3: put(14, 8'h46);
      4: put(23, 8'h06);
      5: put(37, 8'h77);
      default: ;
    endcase
  endtask

  // Frame-level verdict from the raw bytes; stop = beats actually delivered.
  task automatic model_frame(int stop);
    logic        ok;
    logic [47:0] d;
    logic [31:0] sq;
    logic [1:0]  dr;
    int nb, last_b;
    nb = nbeats();
    ok = 1'b0;
    if (flen > 48) begin
      d = '0;
      for (int i = 0; i < 6; i++) d = {d[39:0], fr[i]};
      sq = {fr[44], fr[45], fr[46], fr[47]};
      dr = fr[42][1:0];
      ok = (d == DST) && ({fr[12], fr[13]} == 16'h0800) && (fr[14] == 8'h45) &&
           (fr[23] == 8'h11) && ({fr[36], fr[37]} == DPORT);
    end
    last_b = (stop < nb) ? stop : nb;
    if (ok)
      for (int b = 6; b < last_b; b++)
        exp_q.push_back({dr, rev8(beat_keep(b)), bswap(beat_data(b)), b == nb - 1, tu[b]});
    if (stop >= nb) begin
      if (ok) begin
        m_pkt++;
`ifdef DECAP_SEQ_CHECK_EN
        if (sq != m_exp) m_err++;
`endif
        m_exp = sq + 32'd1;
      end else begin
        m_drop++;
      end
    end
  endtask

  task automatic model_reset();
    m_pkt = 0; m_drop = 0; m_err = 0; m_exp = 32'd1;
    exp_q.delete();
  endtask

  // Drive the first `stop` beats of the current frame with bounded handshake waits.
  task automatic send(int stop);
    int nb, w;
    logic hs;
    nb = nbeats();
    for (int b = 0; b < stop; b++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk156); #1;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = beat_data(b);
      s_axis_tkeep  = beat_keep(b);
      s_axis_tlast  = (b == nb - 1);
      s_axis_tuser  = tu[b];
      hs = 1'b0; w = 0;
      while (!hs) begin
        @(negedge clk156);
        hs = s_axis_tready;
        @(posedge clk156); #1;
        w++;
        if (!hs && w > 300) begin
          total++; bad++;
          $display("FAIL send_timeout beat=%0d actual=no_ready required=ready", b);
          hs = 1'b1;
        end
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk156);
    #1;
  endtask

  task automatic check_cnts(string tag);
    chki({tag, "_pkt"}, int'(pkt_cnt), m_pkt);
    chki({tag, "_drop"}, int'(drop_cnt), m_drop);
    chki({tag, "_seqerr"}, int'(seq_err_cnt), m_err);
  endtask

  // full generator: forced window or random backpressure
  always @(posedge clk156) begin
    #2;
    full = full_force | (full_rand & ($urandom_range(0, 2) == 0));
  end

  // Cycle-by-cycle compare against the model's expected FIFO words.
  always @(negedge clk156) begin
    if (sys_rst) begin
      chk("rst_ready", 76'(s_axis_tready), 76'd0);
      chk("rst_wr_en", 76'(wr_en), 76'd0);
      chk("rst_cnts", 76'({pkt_cnt, drop_cnt, seq_err_cnt}), 76'd0);
    end else begin
      if (wr_en) begin
        n_wr++;
        got_q.push_back(din);
        chk("wr_needs_valid", 76'(s_axis_tvalid), 76'd1);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write actual=%0h required=no_write", din);
        end else begin
          chk("din", din, exp_q.pop_front());
        end
      end else if (s_axis_tvalid && s_axis_tready) begin
        chk("din_idle_zero", din, 76'd0);
      end
      if (rdy_watch) chk("rdy_drop", 76'(s_axis_tready), 76'd1);
    end
  end

  initial begin
    int base, nb;
    logic [31:0] rseq;
    repeat (3) @(posedge clk156);
    #1 sys_rst = 1'b0;
    @(posedge clk156); #1;

    // good 80-byte frame, dir=2, seq=1
    mk_frame(80, 2'd2, 32'd1, 0);
    model_frame(nbeats());
    chki("pin_nexp", exp_q.size(), 4);
    got_q.delete(); base = n_wr;
    send(nbeats()); settle();
    chki("good_writes", n_wr - base, 4);
    chk("good_dir", 76'(got_q[0][75:74]), 76'd2);
    chk("good_last3", 76'(got_q[2][1]), 76'd0);
    chk("good_last4", 76'(got_q[3][1]), 76'd1);
    chki("good_pkt_lit", int'(pkt_cnt), 1);
    check_cnts("good");

    // wrong UDP port
    mk_frame(80, 2'd2, 32'd1, 0);
    fr[36] = 8'h12; fr[37] = 8'h34;
    model_frame(nbeats());
    chki("pin_port_nexp", exp_q.size(), 0);
    base = n_wr; rdy_watch = 1'b1;
    send(nbeats()); settle();
    rdy_watch = 1'b0;
    chki("port_writes", n_wr - base, 0);
    chki("port_drop_lit", int'(drop_cnt), 1);
    check_cnts("port");

    // 5-cycle full window mid-payload
    mk_frame(80, 2'd1, 32'd2, 0);
    model_frame(nbeats());
    base = n_wr;
    fork
      send(nbeats());
      begin
        int i;
        i = 0;
        while (n_wr < base + 2 && i < 500) begin @(negedge clk156); i++; end
        @(posedge clk156); #1;
        full_force = 1'b1;
        repeat (5) begin
          @(negedge clk156);
          chk("full_ready", 76'(s_axis_tready), 76'd0);
          chk("full_wr_en", 76'(wr_en), 76'd0);
        end
        @(posedge clk156); #1;
        full_force = 1'b0;
      end
    join
    settle();
    chki("full_writes", n_wr - base, 4);
    check_cnts("full");

    // 3-beat runt, then a good frame with seq 4
    mk_frame(24, 2'd0, 32'd0, 0);
    model_frame(nbeats());
    send(nbeats()); settle();
    chki("runt_drop_lit", int'(drop_cnt), 2);
    mk_frame(80, 2'd3, 32'd4, 0);
    model_frame(nbeats());
    base = n_wr;
    send(nbeats()); settle();
    chki("after_runt_writes", n_wr - base, 4);
    chki("after_runt_pkt_lit", int'(pkt_cnt), 3);
`ifdef DECAP_SEQ_CHECK_EN
    chki("seq_err_lit", int'(seq_err_cnt), 1);
`else
    chki("seq_err_lit", int'(seq_err_cnt), 0);
`endif
    check_cnts("runt");

    // reset mid-frame at beat 7, leftover beats then arrive as a fresh runt
    mk_frame(80, 2'd2, 32'd9, 0);
    model_frame(7);
    send(7);
    sys_rst = 1'b1;
    repeat (2) @(posedge clk156);
    #1 sys_rst = 1'b0;
    model_reset();
    chki("rst_pkt_lit", int'(pkt_cnt), 0);
    chki("rst_drop_lit", int'(drop_cnt), 0);
    fr = fr[56:$]; tu = tu[7:$]; flen = flen - 56;
    model_frame(nbeats());
    send(nbeats()); settle();
    mk_frame(80, 2'd0, 32'd1, 0);
    model_frame(nbeats());
    send(nbeats()); settle();
    chki("post_rst_pkt_lit", int'(pkt_cnt), 1);
    check_cnts("post_rst");

    // randomized frames with gaps and backpressure
    gap_pct = 20; full_rand = 1'b1; rseq = 32'd2;
    for (int f = 0; f < 40; f++) begin
      rseq = rseq + (($urandom_range(0, 4) == 0) ? 32'd2 : 32'd1);
      mk_frame($urandom_range(8, 140), 2'($urandom), rseq,
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0);
      nb = nbeats();
      model_frame(nb);
      send(nb); settle();
      check_cnts("rand");
    end
    full_rand = 1'b0;
    settle();
    chki("exp_q_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_decap.md
ETH_DECAP -- requirements
Module: eth_decap

Interface
REQ-001 The block SHALL have parameter eth_dst, default 48'h00_11_22_33_44_55, meaning the local MAC address that must match h_dest.
REQ-002 The block SHALL have parameter udp_dport, default 16'h3776, meaning the accepted UDP destination port.
REQ-003 The block SHALL have parameter eth_proto, default ETH_P_IP, meaning the accepted EtherType.
REQ-004 clk156  input  1  the single clock; every register is clocked on its rising edge.
REQ-005 sys_rst  input  1  asynchronous, active-high reset.
REQ-006 s_axis_tvalid / s_axis_tready  input / output  1 / 1  AXI-Stream handshake for the received frame.
REQ-007 s_axis_tdata  input  64  frame data; the first wire byte is in tdata[7:0].
REQ-008 s_axis_tkeep  input  8  byte enables; bit 0 corresponds to tdata[7:0].
REQ-009 s_axis_tlast / s_axis_tuser  input  1 / 1  end of frame / frame error.
REQ-010 wr_en  output  1  TLP FIFO write strobe.
REQ-011 din  output  76  TLP FIFO word, packed as {dir[1:0], tkeep[7:0], tdata[63:0], tlast, tuser}.
REQ-012 full  input  1  TLP FIFO full.
REQ-013 pkt_cnt / drop_cnt / seq_err_cnt  output  32 each  counts of accepted frames, dropped frames and sequence gaps.

Function
REQ-014 The FSM SHALL have states RX_IDLE, RX_HDR, RX_DATA and RX_DROP, with a 3-bit beat counter hdr_cnt.
REQ-015 Before any field compare or FIFO write, each accepted beat SHALL be converted to internal order: tdata through endian_conv64 and tkeep through reverse8.
REQ-016 The 48-byte header is exactly 6 beats (beats 0-5); beats 6 onward are TLP payload.
REQ-017 Header checks SHALL be: h_dest == eth_dst; h_proto == eth_proto; IP version == 4 and ihl == 5; protocol == IP4_PROTO_UDP; UDP dest == udp_dport.
- Each check SHALL be evaluated on the beat that carries the field.
- Failures SHALL be accumulated in a sticky hdr_bad flag.
REQ-018 From the tcap header in beat 5, dir (2 bits) and seq (32 bits) SHALL be latched into registers.
REQ-019 RX_IDLE SHALL go to RX_HDR on the first valid beat; that beat is beat 0 and sets hdr_cnt to 1.
REQ-020 RX_HDR SHALL hold s_axis_tready=1.
- On a beat with tlast before beat 5 (runt frame), the FSM SHALL go to RX_IDLE and increment drop_cnt.
- On beat 5 with hdr_bad set or that beat failing, the FSM SHALL go to RX_DROP; otherwise it goes to RX_DATA.
- If beat 5 also carries tlast, the frame SHALL be dropped and the FSM returns to RX_IDLE.
REQ-021 RX_DATA SHALL drive s_axis_tready = !full and wr_en = s_axis_tvalid && !full, combinationally (zero latency).
- din SHALL be {dir_latched, internal tkeep, internal tdata, tlast, tuser}.
- On the written beat with tlast, the FSM SHALL go to RX_IDLE and increment pkt_cnt.
REQ-022 RX_DROP SHALL hold s_axis_tready=1 and wr_en=0, and on tlast SHALL go to RX_IDLE and increment drop_cnt.
REQ-023 s_axis_tuser SHALL be passed through to din[0] unchanged; the block SHALL NOT drop frames on tuser.
REQ-024 While full=1 in RX_DATA, no beat SHALL be consumed and no data SHALL be lost.
REQ-025 All counters SHALL be 32-bit and wrap from 32'hFFFF_FFFF to 0 without saturating.
REQ-026 In every state other than RX_DATA, wr_en SHALL be 0 and din SHALL be 76'h0.

Reset
REQ-027 While sys_rst=1, the block SHALL hold: FSM in RX_IDLE, hdr_cnt=0, hdr_bad=0, dir and seq latches=0, all counters=0, wr_en=0, s_axis_tready=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame without counting it.
- After release, the block SHALL treat the next valid beat as beat 0.
- Any remaining beats of the abandoned frame are therefore parsed as a new header and normally end up dropped.

Configuration
REQ-029 With macro DECAP_SEQ_CHECK_EN defined, the block SHALL keep an expected-sequence register exp_seq, reset to 1.
- On each accepted frame: if seq != exp_seq, seq_err_cnt increments.
- In both cases exp_seq then becomes seq+1, modulo 2^32.
REQ-030 Without DECAP_SEQ_CHECK_EN, seq_err_cnt SHALL be tied to 32'h0, and no exp_seq register SHALL exist.

Verification
REQ-031 80-byte frame (dst 00:11:22:33:44:55, IP/UDP, dport 3776, dir=2, seq=1) followed by 4 TLP beats → exactly 4 writes, din[75:74]=2, tlast on the 4th write, pkt_cnt=1.
REQ-032 Same frame with dport 16'h1234 → 0 writes, drop_cnt=1, s_axis_tready=1 throughout.
REQ-033 full asserted for 5 cycles in mid-payload → s_axis_tready=0 for those 5 cycles, and all 4 beats are written exactly once, in order.
REQ-034 3-beat runt frame with tlast on beat 2 → drop_cnt=1, and the next valid frame is accepted normally.
REQ-035 With DECAP_SEQ_CHECK_EN, frames with seq 1, 2, 4 → seq_err_cnt=1; without the macro, seq_err_cnt=0.
REQ-036 sys_rst pulsed at beat 7 of a frame → all counters=0 and FSM in RX_IDLE; a following good frame gives pkt_cnt=1.
